// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb/pc-update one instruction at a time.
// Optional MCFSM_MEM_WAIT_EN: hold in MEM until Mem_Ready (default build: single-cycle MEM).
module multicycle_ctrl_fsm (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [31:0] RF_A,
  input  logic [31:0] RF_B,
  input  logic        Mem_Ready,
  output logic        IR_LdEn,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        RF_B_sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        MEM_WrEn,
  output logic        MEM_out_sel,
  output logic        RF_B2_seldir,
  output logic        Instr_Done,
  output logic        Illegal,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StPcInc  = 3'd5,
    StBranch = 3'd6,
    StUnused = 3'd7
  } state_e;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [5:0]  opcode;
  logic        is_alur, is_alui, is_andi, is_ori, is_load, is_lw, is_store, is_sw;
  logic        is_b, is_beq, is_bne, is_br, is_nop, is_ill, taken;

  assign opcode = ir_q[31:26];

  always_comb begin
    is_alur  = (opcode == 6'b100000);
    is_andi  = (opcode == 6'b110010);
    is_ori   = (opcode == 6'b110011);
    is_alui  = (opcode == 6'b111000) || (opcode == 6'b111001) || (opcode == 6'b110000) ||
               is_andi || is_ori;
    is_lw    = (opcode == 6'b001111);
    is_load  = (opcode == 6'b000011) || is_lw;
    is_sw    = (opcode == 6'b011111);
    is_store = (opcode == 6'b000111) || is_sw;
    is_nop   = (ir_q == 32'h0);
    is_b     = (opcode == 6'b111111);
    is_beq   = (opcode == 6'b000000) && !is_nop;
    is_bne   = (opcode == 6'b000001);
    is_br    = is_b || is_beq || is_bne;
    is_ill   = !(is_alur || is_alui || is_load || is_store || is_br || is_nop);
    taken    = is_b || (is_beq && (RF_A == RF_B)) || (is_bne && (RF_A != RF_B));
  end

`ifndef MCFSM_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_Ready;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StFetch;
      ir_q    <= 32'h0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q    <= Instr;
          state_q <= StDecode;
        end
        StDecode: begin
          if (is_br)                state_q <= StBranch;
          else if (is_nop || is_ill) state_q <= StPcInc;
          else                      state_q <= StExec;
        end
        StExec:   state_q <= (is_load || is_store) ? StMem : StWb;
        StMem: begin
`ifdef MCFSM_MEM_WAIT_EN
          if (Mem_Ready) state_q <= is_load ? StWb : StPcInc;
`else
          state_q <= is_load ? StWb : StPcInc;
`endif
        end
        StWb:     state_q <= StPcInc;
        StPcInc:  state_q <= StFetch;
        StBranch: state_q <= StFetch;
        StUnused: state_q <= StFetch;
        default:  state_q <= StFetch;
      endcase
    end
  end

  // Reset gates every output combinationally, so an in-flight store or PC load dies at once.
  always_comb begin
    IR_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_B_sel      = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    MEM_WrEn      = 1'b0;
    MEM_out_sel   = 1'b0;
    RF_B2_seldir  = 1'b0;
    Instr_Done    = 1'b0;
    Illegal       = 1'b0;
    State         = 3'd0;
    if (!Reset) begin
      State = state_q;
      if (state_q != StFetch) begin
        RF_B_sel      = is_store || is_beq || is_bne;
        ALU_Bin_sel   = is_alui || is_load || is_store;
        ALU_func      = is_alur ? ir_q[3:0] : is_andi ? 4'b0010 : is_ori ? 4'b0011 : 4'b0000;
        RF_WrData_sel = is_load;
        MEM_out_sel   = is_lw;
        RF_B2_seldir  = is_sw;
      end
      case (state_q)
        StFetch:  IR_LdEn = 1'b1;
        StDecode: Illegal = is_ill;
        StMem:    MEM_WrEn = is_store;
        StWb:     RF_WrEn = 1'b1;
        StPcInc: begin
          PC_LdEn    = 1'b1;
          Instr_Done = 1'b1;
        end
        StBranch: begin
          PC_LdEn    = 1'b1;
          Instr_Done = 1'b1;
          PC_sel     = taken;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle output compare against a phase-list model.
module tb_multicycle_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic [31:0] RF_A = 32'h0;
  logic [31:0] RF_B = 32'h0;
  logic        Mem_Ready = 1'b0;
  logic        IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_WrEn, MEM_out_sel, RF_B2_seldir, Instr_Done, Illegal;
  logic [2:0]  State;
  logic [18:0] outs;

  int total = 0;
  int bad = 0;

  localparam int CAlu = 0, CLoad = 1, CStore = 2, CBr = 3, CNop = 4, CIll = 5;

  always #5 Clk = ~Clk;

  multicycle_ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .RF_A(RF_A), .RF_B(RF_B), .Mem_Ready(Mem_Ready),
    .IR_LdEn(IR_LdEn), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .RF_B_sel(RF_B_sel),
    .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel), .ALU_Bin_sel(ALU_Bin_sel),
    .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn), .MEM_out_sel(MEM_out_sel),
    .RF_B2_seldir(RF_B2_seldir), .Instr_Done(Instr_Done), .Illegal(Illegal), .State(State)
  );

  assign outs = {IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel, ALU_Bin_sel,
                 ALU_func, MEM_WrEn, MEM_out_sel, RF_B2_seldir, Instr_Done, Illegal, State};

  function automatic int classify(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    if (ir == 32'h0) return CNop;
    case (op)
      6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011: return CAlu;
      6'b000011, 6'b001111: return CLoad;
      6'b000111, 6'b011111: return CStore;
      6'b111111, 6'b000000, 6'b000001: return CBr;
      default: return CIll;
    endcase
  endfunction

  // Runs one instruction from FETCH; abort_at>0 asserts Reset in that cycle and stops.
  task automatic run_instr(input string name, input logic [31:0] instr, input logic [31:0] ra,
                           input logic [31:0] rb, input int w_in, input int abort_at);
    int cls, w, len, mem_idx, s;
    int st[$];
    logic [5:0] op;
    logic [31:0] junk;
    logic [18:0] exp_v;
    logic taken, first, rf_b_sel, bin, wrdata, mem_out, b2;
    logic [3:0] func;
    cls = classify(instr);
    op = instr[31:26];
    w = 0;
`ifdef MCFSM_MEM_WAIT_EN
    w = w_in;
`else
    if (w_in < 0) w = 0;
`endif
    st.push_back(0);
    st.push_back(1);
    case (cls)
      CAlu: begin st.push_back(2); st.push_back(4); st.push_back(5); end
      CLoad: begin
        st.push_back(2);
        for (int k = 0; k <= w; k++) st.push_back(3);
        st.push_back(4); st.push_back(5);
      end
      CStore: begin
        st.push_back(2);
        for (int k = 0; k <= w; k++) st.push_back(3);
        st.push_back(5);
      end
      CBr: st.push_back(6);
      default: st.push_back(5);
    endcase
    len = st.size();
    taken = (op == 6'b111111) || (op == 6'b000000 && ra == rb) || (op == 6'b000001 && ra != rb);
    rf_b_sel = (cls == CStore) || (cls == CBr && op != 6'b111111);
    bin = (cls == CStore) || (cls == CLoad) || (cls == CAlu && op != 6'b100000);
    func = (op == 6'b100000) ? instr[3:0] : (op == 6'b110010) ? 4'd2 :
           (op == 6'b110011) ? 4'd3 : 4'd0;
    wrdata = (cls == CLoad);
    mem_out = (op == 6'b001111);
    b2 = (op == 6'b011111);
    mem_idx = 0;
    for (int c = 1; c <= len; c++) begin
      @(negedge Clk);
      Reset = 1'b0;
      junk = $urandom;
      Instr = (c == 1) ? instr : junk;
      RF_A = ra;
      RF_B = rb;
      Mem_Ready = 1'($urandom_range(0, 1));
      s = st[c-1];
`ifdef MCFSM_MEM_WAIT_EN
      if (s == 3) Mem_Ready = (mem_idx >= w);
`endif
      if (s == 3) mem_idx++;
      if (c == abort_at) begin
        Reset = 1'b1;
        #1;
        total++;
        if (outs !== 19'h0) begin
          bad++;
          $display("FAIL %s abort cycle %0d: got %b want all zero", name, c, outs);
        end
        return;
      end
      #1;
      first = (c == 1);
      exp_v = {first, (c == len) && (cls == CBr) && taken, c == len,
               !first && rf_b_sel, (cls == CAlu || cls == CLoad) && c == len - 1,
               !first && wrdata, !first && bin, first ? 4'd0 : func,
               (cls == CStore) && c >= 4 && c < len, !first && mem_out, !first && b2,
               c == len, (cls == CIll) && c == 2, 3'(s)};
      total++;
      if (outs !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d/%0d: got %b want %b", name, c, len, outs, exp_v);
      end
    end
  endtask

  task automatic hold_reset(input int n, input logic [31:0] instr);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Reset = 1'b1;
      Instr = instr;
      Mem_Ready = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (outs !== 19'h0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got %b want all zero", i, outs);
      end
    end
  endtask

  task automatic test_reset();
    hold_reset(3, 32'h8043_0000);
    run_instr("alu_r_after_reset", 32'h8043_0000, 32'h1, 32'h2, 0, 0);
  endtask

  task automatic test_alu();
    run_instr("ori", 32'hCC22_000F, 32'h0, 32'h0, 0, 0);
    run_instr("andi", {6'b110010, 26'h0123456}, 32'h0, 32'h0, 0, 0);
    run_instr("alu_r_func", {6'b100000, 26'h000A5F7}, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_load();
    run_instr("lw", {6'b001111, 26'h0420004}, 32'h0, 32'h0, 0, 0);
    run_instr("lb", {6'b000011, 26'h0420004}, 32'h0, 32'h0, 0, 0);
    run_instr("lw_wait", {6'b001111, 26'h0001111}, 32'h0, 32'h0, 2, 0);
  endtask

  task automatic test_store();
    run_instr("sw_wait3", {6'b011111, 26'h0230008}, 32'h0, 32'h0, 3, 0);
    run_instr("sb", {6'b000111, 26'h0230008}, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_eq", {6'b000000, 26'h0220010}, 32'd5, 32'd5, 0, 0);
    run_instr("beq_ne", {6'b000000, 26'h0220010}, 32'd5, 32'd6, 0, 0);
    run_instr("bne_ne", {6'b000001, 26'h0220010}, 32'd5, 32'd6, 0, 0);
    run_instr("bne_eq", {6'b000001, 26'h0220010}, 32'd7, 32'd7, 0, 0);
    run_instr("b", {6'b111111, 26'h0000010}, 32'd1, 32'd2, 0, 0);
  endtask

  task automatic test_nop_illegal();
    run_instr("nop", 32'h0000_0000, 32'h0, 32'h0, 0, 0);
    run_instr("illegal", {6'b101010, 26'h1234567}, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_instr("sw_abort_in_mem", {6'b011111, 26'h0230008}, 32'h0, 32'h0, 2, 4);
    run_instr("alu_after_abort", 32'h8043_0003, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] ir, ra, rb, lo;
    logic [5:0] op;
    logic [5:0] ops [14] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                             6'b110011, 6'b000011, 6'b001111, 6'b000111, 6'b011111,
                             6'b111111, 6'b000000, 6'b000001, 6'b010101};
    for (int i = 0; i < 150; i++) begin
      lo = $urandom;
      op = ops[$urandom_range(0, 13)];
      ir = (i % 23 == 0) ? 32'h0 : {op, lo[25:0]};
      ra = $urandom_range(0, 3);
      rb = $urandom_range(0, 3);
      run_instr("random", ir, ra, rb, int'($urandom_range(0, 3)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_nop_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
